// File: rtl/i2c_config_seq_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
package i2c_config_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StStart,
    StAddr,
    StData,
    StAck,
    StStop,
    StGap,
    StFinish
  } state_e;

  // Quarter phases of one bus bit period.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // R/W bit appended to the slave address; this block only writes.
  localparam logic I2cWrite = 1'b0;

  // Bus line levels for a given state/quarter, returned as {scl, sda_oe}.
  // Non-bus states park the bus idle: SCL high, SDA released.
  function automatic logic [1:0] bus_drive(state_e st, logic [1:0] qtr, logic bit_val);
    logic scl;
    logic oe;
    scl = 1'b1;
    oe  = 1'b0;
    case (st)
      StStart: begin
        scl = (qtr != Q3);
        oe  = (qtr == Q2) || (qtr == Q3);
      end
      StAddr, StData: begin
        scl = (qtr == Q1) || (qtr == Q2);
        oe  = ~bit_val;
      end
      StAck: begin
        scl = (qtr == Q1) || (qtr == Q2);
        oe  = 1'b0;
      end
      StStop: begin
        scl = (qtr != Q0);
        oe  = (qtr == Q0) || (qtr == Q1);
      end
      default: begin
        scl = 1'b1;
        oe  = 1'b0;
      end
    endcase
    return {scl, oe};
  endfunction

endpackage

// File: rtl/i2c_config_seq_if.sv
// Host, table and I2C pin bundle of the configuration sequencer.
interface i2c_config_seq_if #(
  parameter int unsigned DATA_BYTES = 2
) ();
  logic                    start;
  logic [7:0]              tbl_addr;
  logic [8*DATA_BYTES-1:0] tbl_data;
  logic                    i2c_sclk;
  logic                    i2c_sda_oe;
  logic                    i2c_sda_in;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [7:0]              err_index;

  // Sequencer side.
  modport master (
    input  start, tbl_data, i2c_sda_in,
    output tbl_addr, i2c_sclk, i2c_sda_oe, busy, done, error, err_index
  );

  // Host / table / bus side.
  modport slave (
    output start, tbl_data, i2c_sda_in,
    input  tbl_addr, i2c_sclk, i2c_sda_oe, busy, done, error, err_index
  );
endinterface

// File: rtl/i2c_qtick_gen.sv
// Quarter-tick divider: one-cycle tick every CLK_DIV cycles while enabled.
module i2c_qtick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count while enabled, hold cleared otherwise so phases start aligned.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_config_seq.sv
// Walks a register table and writes each entry to an I2C slave, retrying NACKs.
module i2c_config_seq
  import i2c_config_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 10,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned DATA_BYTES = 2,
  parameter int unsigned CLK_DIV    = 125,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic              clk,
  input logic              reset,
  i2c_config_seq_if.master bus
);
  localparam int unsigned DataW    = 8 * DATA_BYTES;
  localparam logic [2:0]  LastByte = 3'(DATA_BYTES);
  localparam logic [7:0]  LastIdx  = 8'(NUM_REGS - 1);
  localparam logic [7:0]  MaxRetry = 8'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;     // 0 = address byte, 1..DATA_BYTES = payload
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       retry_q, retry_d;
  logic             rflag_q, rflag_d;
  logic             ack_q, ack_d;
  logic             fetch_q, fetch_d;
  logic [DataW-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [7:0]       err_idx_q, err_idx_d;
  logic             sclk_q, sclk_d;
  logic             sda_oe_q, sda_oe_d;

  logic       tick;
  logic       bus_active;
  logic [7:0] tx_byte;

  // Divider only runs in bus states so every bus phase starts on a full quarter.
  assign bus_active = state_q inside {StStart, StAddr, StData, StAck, StStop, StGap};

  i2c_qtick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_qtick (
    .clk  (clk),
    .reset(reset),
    .en   (bus_active),
    .tick (tick)
  );

  // Byte on the wire for the upcoming bit, payload sent MSB byte first.
  always_comb begin
    tx_byte = {DEV_ADDR, I2cWrite};
    for (int k = 1; k <= int'(DATA_BYTES); k++) begin
      if (int'(byte_d) == k) tx_byte = data_q[8*(int'(DATA_BYTES)-k) +: 8];
    end
  end

  // Sequencer next-state; pin levels derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    rflag_d   = rflag_q;
    ack_d     = ack_q;
    fetch_d   = fetch_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          retry_d = '0;
          rflag_d = 1'b0;
          busy_d  = 1'b1;
          idx_d   = '0;
          fetch_d = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Table answers one cycle after the address moves; take it on the second cycle.
        if (fetch_q) begin
          data_d  = bus.tbl_data;
          qtr_d   = Q0;
          state_d = StStart;
        end else begin
          fetch_d = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) begin
            byte_d  = '0;
            bit_d   = 3'd7;
            state_d = StAddr;
          end
        end
      end
      StAddr, StData: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) begin
            if (bit_q == 3'd0) state_d = StAck;
            else               bit_d   = bit_q - 3'd1;
          end
        end
      end
      StAck: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q2) ack_d = bus.i2c_sda_in;
          if (qtr_q == Q3) begin
            if (ack_q) begin
              rflag_d = 1'b1;
              state_d = StStop;
            end else if (byte_q == LastByte) begin
              state_d = StStop;
            end else begin
              byte_d  = byte_q + 3'd1;
              bit_d   = 3'd7;
              state_d = StData;
            end
          end
        end
      end
      StStop: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) state_d = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == Q3) begin
            rflag_d = 1'b0;
            fetch_d = 1'b0;
            if (rflag_q && (retry_q < MaxRetry)) begin
              retry_d = retry_q + 8'd1;
              state_d = StFetch;
            end else if (rflag_q) begin
              error_d   = 1'b1;
              err_idx_d = idx_q;
              state_d   = StFinish;
            end else begin
              retry_d = '0;
              if (idx_q == LastIdx) begin
                done_d  = 1'b1;
                state_d = StFinish;
              end else begin
                idx_d   = idx_q + 8'd1;
                state_d = StFetch;
              end
            end
          end
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    {sclk_d, sda_oe_d} = bus_drive(state_d, qtr_d, tx_byte[bit_d]);
  end

  // State and registered outputs; reset drops the bus straight to idle without a STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      qtr_q     <= Q0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      retry_q   <= '0;
      rflag_q   <= 1'b0;
      ack_q     <= 1'b0;
      fetch_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      sclk_q    <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      rflag_q   <= rflag_d;
      ack_q     <= ack_d;
      fetch_q   <= fetch_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      sclk_q    <= sclk_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign bus.tbl_addr   = idx_q;
  assign bus.i2c_sclk   = sclk_q;
  assign bus.i2c_sda_oe = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_index  = err_idx_q;
endmodule

// File: tb/tb_i2c_config_seq.sv
// Directed bench: table model, I2C slave/bus monitor, checks on logged bus traffic.
module tb_i2c_config_seq;
  localparam int unsigned DataBytes = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2c_config_seq_if #(.DATA_BYTES(DataBytes)) bus ();

  i2c_config_seq #(
    .NUM_REGS  (2),
    .DEV_ADDR  (7'h1A),
    .DATA_BYTES(DataBytes),
    .CLK_DIV   (4),
    .MAX_RETRY (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Register table with one-cycle read latency.
  logic [15:0] tbl [2] = '{16'h0097, 16'h0297};
  always @(posedge clk)
    bus.tbl_data <= (bus.tbl_addr < 8'd2) ? tbl[bus.tbl_addr[0]] : 16'hDEAD;

  // Open-drain SDA: low if either side pulls.
  logic slave_pull = 1'b0;
  logic sda_line;
  assign sda_line       = ~(bus.i2c_sda_oe | slave_pull);
  assign bus.i2c_sda_in = sda_line;

  // Monitor/slave state. log entries: 256 = START, 257 = STOP, else a byte.
  int         log[$];
  int         cyc        = 0;
  int         bitcnt     = 0;
  int         pos        = 0;
  int         frame      = 0;
  int         last_rise  = 0;
  int         per_n      = 0;
  int         per_bad    = 0;
  int         mode       = 0;   // 0 ack all, 1 nack one data byte once, 2 nack address
  int         nack_frame = -1;
  logic       first_rise = 1'b1;
  logic       prev_scl   = 1'b1;
  logic       prev_sda   = 1'b1;
  logic [7:0] sh         = 8'h00;
  logic       ack_now;

  always @(negedge clk) begin
    logic scl;
    logic sda;
    scl = bus.i2c_sclk;
    sda = sda_line;
    cyc++;
    if (prev_scl && scl && prev_sda && !sda) begin
      log.push_back(256);
      frame++;
      bitcnt     = 0;
      pos        = 0;
      first_rise = 1'b1;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      log.push_back(257);
    end else if (!prev_scl && scl) begin
      if (!first_rise) begin
        per_n++;
        if (cyc - last_rise != 16) per_bad++;
      end
      first_rise = 1'b0;
      last_rise  = cyc;
      if (bitcnt < 8) begin
        sh = {sh[6:0], sda};
        bitcnt++;
      end else begin
        bitcnt = 0;
        pos++;
      end
    end else if (prev_scl && !scl) begin
      if (bitcnt == 8) begin
        log.push_back(int'(sh));
        case (mode)
          1:       ack_now = !((frame == nack_frame) && (pos == 1));
          2:       ack_now = (pos != 0);
          default: ack_now = 1'b1;
        endcase
        slave_pull = ack_now;
      end else begin
        slave_pull = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int base, input int exp[$]);
    chk({tag, "_len"}, 32'(log.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (base + i < log.size()) chk(tag, 32'(log[base+i]), 32'(exp[i]));
  endtask

  task automatic pulse_start(input int cycles);
    bus.start = 1'b1;
    repeat (cycles) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   e1[$];
    int   e2[$];
    int   e3[$];
    int   base;
    int   pb;
    int   pn;
    int   fb;
    logic found;

    e1 = '{256, 'h34, 'h00, 'h97, 257, 256, 'h34, 'h02, 'h97, 257};
    e2 = '{256, 'h34, 'h00, 'h97, 257, 256, 'h34, 'h02, 257, 256, 'h34, 'h02, 'h97, 257};
    e3 = '{256, 'h34, 257, 256, 'h34, 257, 256, 'h34, 257, 256, 'h34, 257};

    // Reset state.
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(bus.i2c_sclk), 32'd1);
    chk("rst_sda_oe", 32'(bus.i2c_sda_oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_err_index", 32'(bus.err_index), 32'd0);
    chk("rst_tbl_addr", 32'(bus.tbl_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Always-ACK run: two full writes, exact 16-cycle SCL period.
    mode = 0;
    base = log.size();
    pb   = per_bad;
    pn   = per_n;
    pulse_start(1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_idle("t1");
    chk_log("t1_log", base, e1);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_error", 32'(bus.error), 32'd0);
    chk("t1_scl_period_bad", 32'(per_bad - pb), 32'd0);
    chk("t1_scl_period_seen", 32'(per_n - pn > 20), 32'd1);

    // One NACK on first data byte of index 1: that entry resent once.
    mode       = 1;
    nack_frame = frame + 2;
    base       = log.size();
    pulse_start(1);
    wait_idle("t2");
    chk_log("t2_log", base, e2);
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_error", 32'(bus.error), 32'd0);

    // Address always NACKed: four attempts then error.
    mode = 2;
    base = log.size();
    pulse_start(1);
    wait_idle("t3");
    chk_log("t3_log", base, e3);
    chk("t3_error", 32'(bus.error), 32'd1);
    chk("t3_err_index", 32'(bus.err_index), 32'd0);
    chk("t3_done", 32'(bus.done), 32'd0);
    chk("t3_busy", 32'(bus.busy), 32'd0);

    // Reset during bit 5 of byte 2, then a clean run from index 0.
    mode = 0;
    fb   = frame;
    pulse_start(1);
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (frame == fb + 1 && pos == 2 && bitcnt == 5) found = 1'b1;
    end
    chk("t4_reached_bit5", 32'(found), 32'd1);
    repeat (9) @(negedge clk);
    chk("t4_pre_sclk_low", 32'(bus.i2c_sclk), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_sclk", 32'(bus.i2c_sclk), 32'd1);
    chk("t4_sda_oe", 32'(bus.i2c_sda_oe), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_tbl_addr", 32'(bus.tbl_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    base = log.size();
    pulse_start(1);
    wait_idle("t4");
    chk_log("t4_log", base, e1);
    chk("t4_done", 32'(bus.done), 32'd1);

    // Start held 3 cycles, pulsed mid-run and during FINISH: one run only.
    base = log.size();
    pulse_start(3);
    repeat (100) @(negedge clk);
    chk("t5_busy_mid", 32'(bus.busy), 32'd1);
    pulse_start(1);
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      @(negedge clk);
      if (bus.done && bus.busy) found = 1'b1;
    end
    chk("t5_finish_seen", 32'(found), 32'd1);
    pulse_start(1);
    repeat (40) @(negedge clk);
    chk("t5_busy_after", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_error", 32'(bus.error), 32'd0);
    chk_log("t5_log", base, e1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_config_seq.md
I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 10, meaning the number of register-write transactions per run (1..255).
REQ-002 The block SHALL have parameter DEV_ADDR, default 7'h1A, meaning the 7-bit I2C slave address sent with R/W=0.
REQ-003 The block SHALL have parameter DATA_BYTES, default 2, meaning the payload bytes per transaction (1..4), MSB byte first.
REQ-004 The block SHALL have parameter CLK_DIV, default 125, meaning clk cycles per quarter SCL period (>=2).
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, meaning retries of a NACKed transaction before error.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, meaning a one-cycle request to begin a run; ignored while busy.
REQ-009 The block SHALL have port tbl_addr, output, 8 bits, meaning the table index being fetched.
REQ-010 The block SHALL have port tbl_data, input, 8*DATA_BYTES bits, meaning the table payload, valid one clk after tbl_addr changes.
REQ-011 The block SHALL have port i2c_sclk, output, 1 bit, meaning SCL, driven push-pull.
REQ-012 The block SHALL have port i2c_sda_oe, output, 1 bit, meaning that 1 pulls SDA low and 0 releases it (open drain).
REQ-013 The block SHALL have port i2c_sda_in, input, 1 bit, meaning the sampled SDA line level.
REQ-014 The block SHALL have port busy, output, 1 bit, meaning a run is in progress.
REQ-015 The block SHALL have port done, output, 1 bit, meaning the last run completed with all ACKs; held until next start.
REQ-016 The block SHALL have port error, output, 1 bit, meaning the last run aborted after retries were exhausted; held until next start.
REQ-017 The block SHALL have port err_index, output, 8 bits, meaning the table index of the failing transaction.

Function
REQ-018 The block SHALL generate a quarter-tick every CLK_DIV clk cycles while busy, with the divider cleared when not busy; every bus phase SHALL span 4 quarter-ticks.
REQ-019 The FSM SHALL have exactly the states IDLE, FETCH, START, ADDR, DATA, ACK, STOP, GAP, FINISH.
REQ-020 IDLE: start=1 SHALL clear done, error and the retry count, set busy, set index=0 and go to FETCH.
REQ-021 FETCH: tbl_addr=index SHALL be held and tbl_data latched on the second cycle, then the FSM SHALL go to START.
REQ-022 START: SDA released with SCL high for quarters 0-1, then SDA pulled low at quarter 2 and SCL taken low at quarter 3.
REQ-023 ADDR/DATA: bits SHALL be sent MSB first; SDA changes only at quarter 0 with SCL low, SCL is high in quarters 1-2 and low in quarter 3.
REQ-024 ACK: after every 8 bits the block SHALL release SDA and sample i2c_sda_in once at the end of quarter 2.
REQ-025 An ACK of 0 SHALL advance to the next byte, or to STOP after byte DATA_BYTES.
REQ-026 An ACK of 1 SHALL go to STOP with the retry flag set.
REQ-027 STOP: SDA low with SCL low in quarter 0, SCL high in quarter 1, SDA released in quarter 2, hold in quarter 3.
REQ-028 GAP: after STOP the block SHALL hold the bus idle (SCL=1, SDA released) for 4 quarters.
REQ-029 GAP, retry flag set and retries < MAX_RETRY: the retry count SHALL increment and the FSM SHALL go to FETCH with the same index.
REQ-030 GAP, retry flag set and retries = MAX_RETRY: the block SHALL set error, set err_index=index and go to FINISH.
REQ-031 GAP, no retry: the retry count SHALL clear and index SHALL increment; index = NUM_REGS-1 SHALL set done and go to FINISH, otherwise the FSM SHALL go to FETCH.
REQ-032 FINISH: busy SHALL clear on the next cycle, with the FSM returning to IDLE.
REQ-033 Outputs SHALL only change at quarter-tick boundaries during bus states; i2c_sclk and i2c_sda_oe SHALL be registered and glitch-free.
REQ-034 A start pulse coincident with FINISH SHALL be ignored; start is accepted only in IDLE.
REQ-035 done and error SHALL never be 1 simultaneously.

Reset
REQ-036 On reset=1 the FSM SHALL go to IDLE, and the block SHALL set i2c_sclk=1, i2c_sda_oe=0, busy=0, done=0, error=0, err_index=0, tbl_addr=0 and clear the divider and counters.
REQ-037 Reset asserted mid-transaction SHALL abort immediately without issuing STOP; the bus is released on the next clk.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the quarter-phase constants and the I2C write-bit constant.
REQ-039 The quarter-tick divider SHALL be one sub-module, i2c_qtick_gen, with ports clk, reset, en and tick.

Verification
REQ-040 NUM_REGS=2, DATA_BYTES=2, CLK_DIV=4, always-ACK slave, table {16'h0097, 16'h0297} -> bus bytes 34,00,97 then 34,02,97, two START/STOP pairs, done=1, error=0.
REQ-041 Slave NACKs the first data byte of index 1 once -> index 1 is resent in full exactly once and done=1.
REQ-042 Slave always NACKs the address, MAX_RETRY=3 -> 4 attempts on index 0, then error=1, err_index=0, done=0, busy=0.
REQ-043 reset pulsed during bit 5 of byte 2 -> next clk shows i2c_sclk=1, i2c_sda_oe=0, busy=0, and a fresh start runs from index 0.
REQ-044 start held high for 3 cycles in IDLE, then pulsed while busy -> exactly one run occurs.
REQ-045 CLK_DIV=4 -> SCL period is exactly 16 clk cycles, and SDA never changes while SCL=1 except at START/STOP.
